// File: rtl/fu_sequencer_pkg.sv
// Shared definitions for the function-unit sequencer: FSM states,
// instruction field positions and F_sel field positions.
package fu_sequencer_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Register file geometry.
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;

    // Instruction word layout.
    localparam int INSTR_SEL_HI = 15;
    localparam int INSTR_SEL_LO = 12;
    localparam int INSTR_RD_HI  = 11;
    localparam int INSTR_RD_LO  = 10;
    localparam int INSTR_RA_HI  = 9;
    localparam int INSTR_RA_LO  = 8;
    localparam int INSTR_RB_HI  = 7;
    localparam int INSTR_RB_LO  = 6;
    localparam int INSTR_USE_IMM = 5;
    localparam int INSTR_WB_EN  = 4;
    localparam int INSTR_IMM_HI = 3;
    localparam int INSTR_IMM_LO = 0;

    // F_sel layout as understood by the function unit.
    localparam int SEL_LOGIC  = 3;
    localparam int SEL_OP_HI  = 2;
    localparam int SEL_OP_LO  = 1;
    localparam int SEL_CIN    = 0;

endpackage

// File: rtl/fu_sequencer_regfile.sv
// Four-entry register file: one synchronous write port, three
// combinational read ports (two operand reads plus a debug read).
module fu_regfile
    import fu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [REG_IDX_W-1:0] ra_addr,
    output logic [WIDTH-1:0]     ra_data,
    input  logic [REG_IDX_W-1:0] rb_addr,
    output logic [WIDTH-1:0]     rb_data,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    // Register storage: cleared on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/fu_sequencer.sv
// Instruction sequencer in front of a fixed-latency function unit.
// Reads operands at accept, holds them stable at the unit, samples the
// result after FU_LATENCY cycles, optionally writes it back and reports it.
//
// Handshake: an instruction transfers on a rising edge where both
// instr_valid and instr_ready are 1. instr_ready is high only in IDLE
// (and never while rst_n is low); instr_valid is ignored otherwise.
// res_valid is a one-cycle pulse with no back-pressure.
module fu_sequencer
    import fu_sequencer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int FU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [3:0]       fu_sel,
    input  logic [WIDTH-1:0] fu_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_rd,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int CNT_W = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1;

    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic           accept;
    logic           sample;
    logic [1:0]     rd_q;
    logic           wb_en_q;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic [WIDTH-1:0] b_operand;

    fu_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (sample & wb_en_q),
        .waddr    (rd_q),
        .wdata    (fu_out),
        .ra_addr  (instr[INSTR_RA_HI:INSTR_RA_LO]),
        .ra_data  (ra_data),
        .rb_addr  (instr[INSTR_RB_HI:INSTR_RB_LO]),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Immediate is zero-extended; otherwise B comes from the register file.
    assign b_operand = instr[INSTR_USE_IMM] ? WIDTH'(instr[INSTR_IMM_HI:INSTR_IMM_LO])
                                            : rb_data;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: state_next = (FU_LATENCY == 0) ? ST_WRITE : ST_WAIT;
            ST_WAIT:  if (wait_cnt == '0) state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, result pulse and the fu_out sample strobe.
    always_comb begin
        instr_ready = rst_n && (state == ST_IDLE);
        accept      = instr_ready && instr_valid;
        res_valid   = (state == ST_WRITE);
        sample      = ((state == ST_ISSUE) && (FU_LATENCY == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == '0));
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= CNT_W'(FU_LATENCY - 1);
        end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Operand/select registers: loaded on accept, held until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fu_a    <= '0;
            fu_b    <= '0;
            fu_sel  <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
        end else if (accept) begin
            fu_a    <= ra_data;
            fu_b    <= b_operand;
            fu_sel  <= instr[INSTR_SEL_HI:INSTR_SEL_LO];
            rd_q    <= instr[INSTR_RD_HI:INSTR_RD_LO];
            wb_en_q <= instr[INSTR_WB_EN];
        end
    end

    // Result capture on the sample edge; held until the next result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data <= '0;
            res_rd   <= '0;
        end else if (sample) begin
            res_data <= fu_out;
            res_rd   <= rd_q;
        end
    end

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer. Three instances cover FU_LATENCY 1, 0
// and 3; each sits behind a stub function unit computing A+B+F_sel mod 16
// delayed by its latency. A selector routes the shared stimulus and the
// observed outputs to one instance at a time.
module tb_fu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        valid_req;
    logic [15:0] instr;
    logic [1:0]  dbg_addr;
    int          cur;

    int n_checks;
    int n_pass;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance: FU_LATENCY = 1 ----------------
    logic       v_l1, rdy_l1, rv_l1;
    logic [3:0] a_l1, b_l1, s_l1, fo_l1, rd_l1, dbg_l1, p1;
    logic [1:0] rr_l1;
    assign v_l1 = valid_req && (cur == 0);
    always @(posedge clk) p1 <= a_l1 + b_l1 + s_l1;
    assign fo_l1 = p1;

    fu_sequencer #(.WIDTH(4), .FU_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v_l1), .instr_ready(rdy_l1),
        .instr(instr), .fu_a(a_l1), .fu_b(b_l1), .fu_sel(s_l1), .fu_out(fo_l1),
        .res_valid(rv_l1), .res_data(rd_l1), .res_rd(rr_l1),
        .dbg_addr(dbg_addr), .dbg_data(dbg_l1)
    );

    // ---------------- instance: FU_LATENCY = 0 ----------------
    logic       v_l0, rdy_l0, rv_l0;
    logic [3:0] a_l0, b_l0, s_l0, fo_l0, rd_l0, dbg_l0;
    logic [1:0] rr_l0;
    assign v_l0  = valid_req && (cur == 1);
    assign fo_l0 = a_l0 + b_l0 + s_l0;

    fu_sequencer #(.WIDTH(4), .FU_LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v_l0), .instr_ready(rdy_l0),
        .instr(instr), .fu_a(a_l0), .fu_b(b_l0), .fu_sel(s_l0), .fu_out(fo_l0),
        .res_valid(rv_l0), .res_data(rd_l0), .res_rd(rr_l0),
        .dbg_addr(dbg_addr), .dbg_data(dbg_l0)
    );

    // ---------------- instance: FU_LATENCY = 3 ----------------
    logic       v_l3, rdy_l3, rv_l3;
    logic [3:0] a_l3, b_l3, s_l3, fo_l3, rd_l3, dbg_l3, p3_0, p3_1, p3_2;
    logic [1:0] rr_l3;
    assign v_l3 = valid_req && (cur == 2);
    always @(posedge clk) begin
        p3_0 <= a_l3 + b_l3 + s_l3;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign fo_l3 = p3_2;

    fu_sequencer #(.WIDTH(4), .FU_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v_l3), .instr_ready(rdy_l3),
        .instr(instr), .fu_a(a_l3), .fu_b(b_l3), .fu_sel(s_l3), .fu_out(fo_l3),
        .res_valid(rv_l3), .res_data(rd_l3), .res_rd(rr_l3),
        .dbg_addr(dbg_addr), .dbg_data(dbg_l3)
    );

    // ---------------- observation mux ----------------
    logic       m_rdy, m_rv;
    logic [3:0] m_a, m_b, m_s, m_rd, m_dbg;
    logic [1:0] m_rr;
    always_comb begin
        m_rdy = rdy_l1; m_rv = rv_l1; m_a = a_l1; m_b = b_l1; m_s = s_l1;
        m_rd = rd_l1; m_rr = rr_l1; m_dbg = dbg_l1;
        if (cur == 1) begin
            m_rdy = rdy_l0; m_rv = rv_l0; m_a = a_l0; m_b = b_l0; m_s = s_l0;
            m_rd = rd_l0; m_rr = rr_l0; m_dbg = dbg_l0;
        end else if (cur == 2) begin
            m_rdy = rdy_l3; m_rv = rv_l3; m_a = a_l3; m_b = b_l3; m_s = s_l3;
            m_rd = rd_l3; m_rr = rr_l3; m_dbg = dbg_l3;
        end
    end

    // res_valid pulse counters per instance
    int pulses_l1, pulses_l0, pulses_l3;
    initial begin
        pulses_l1 = 0; pulses_l0 = 0; pulses_l3 = 0;
    end
    always @(posedge clk) begin
        if (rv_l1) pulses_l1 <= pulses_l1 + 1;
        if (rv_l0) pulses_l0 <= pulses_l0 + 1;
        if (rv_l3) pulses_l3 <= pulses_l3 + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] sel, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic ui, input logic wb,
                                       input logic [3:0] imm);
        return {sel, rd, ra, rb, ui, wb, imm};
    endfunction

    // ---------------- driver tasks ----------------
    // Offer one instruction for a single cycle; the DUT must be in IDLE.
    // Returns at the negedge of the ISSUE cycle.
    task automatic issue(input logic [15:0] w);
        instr     = w;
        valid_req = 1'b1;
        @(negedge clk);
        valid_req = 1'b0;
    endtask

    // Wait (bounded) for res_valid, check latency/data/rd, then step to IDLE.
    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [3:0] exp_data, input logic [1:0] exp_rd);
        int n;
        n = 0;
        while (!m_rv && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_data"}, m_rd, exp_data);
        check({tag, "_rd"}, m_rr, exp_rd);
        @(negedge clk);
    endtask

    task automatic check_dbg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, m_dbg, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cur       = 0;
        rst_n     = 1'b0;
        valid_req = 1'b0;
        instr     = '0;
        dbg_addr  = '0;

        // Reset, then idle
        repeat (3) @(negedge clk);
        check("rst_ready", m_rdy, 0);
        check("rst_fu_a", m_a, 0);
        check("rst_fu_b", m_b, 0);
        check("rst_fu_sel", m_s, 0);
        check("rst_res_valid", m_rv, 0);
        check("rst_res_data", m_rd, 0);
        check("rst_res_rd", m_rr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", m_rdy, 1);
        for (int i = 0; i < 4; i++) check_dbg("post_rst_reg", 2'(i), 4'h0);
        repeat (2) @(negedge clk);

        // Immediate loads, latency 1: reg1=5, reg2=3
        issue(mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 4'h5));
        check("imm_fu_a", m_a, 4'h0);
        check("imm_fu_b", m_b, 4'h5);
        check("imm_busy", m_rdy, 0);
        wait_result("imm_load", 2, 4'h5, 2'd1);
        check_dbg("imm_reg1", 2'd1, 4'h5);
        issue(mk(4'h0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 4'h3));
        wait_result("imm_load2", 2, 4'h3, 2'd2);

        // Register op with valid held through the busy window
        instr     = mk(4'b0010, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1, 4'h0);
        valid_req = 1'b1;
        @(negedge clk);  // T+1
        instr = mk(4'h1, 2'd0, 2'd3, 2'd0, 1'b1, 1'b1, 4'h4);
        check("regop_ready_t1", m_rdy, 0);
        check("regop_fu_a", m_a, 4'h5);
        check("regop_fu_b", m_b, 4'h3);
        check("regop_fu_sel", m_s, 4'b0010);
        @(negedge clk);  // T+2
        check("regop_ready_t2", m_rdy, 0);
        @(negedge clk);  // T+3
        check("regop_ready_t3", m_rdy, 0);
        check("regop_res_valid", m_rv, 1);
        check("regop_res_data", m_rd, 4'hA);
        check("regop_res_rd", m_rr, 2'd3);
        @(negedge clk);  // T+4
        check("regop_ready_t4", m_rdy, 1);
        check("held_not_early", m_s, 4'b0010);
        @(negedge clk);  // T+5, second instruction in ISSUE
        valid_req = 1'b0;
        check("held_fu_sel", m_s, 4'h1);
        check("held_fu_a", m_a, 4'hA);
        check("held_fu_b", m_b, 4'h4);
        wait_result("held", 2, 4'hF, 2'd0);

        // Wrap and self-update on reg0
        issue(mk(4'h1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0));
        check("wrap_fu_a", m_a, 4'hF);
        check("wrap_fu_b", m_b, 4'hF);
        wait_result("wrap", 2, 4'hF, 2'd0);
        issue(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0));
        wait_result("self1", 2, 4'hE, 2'd0);
        issue(mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0));
        check("self2_fu_a", m_a, 4'hE);
        check("self2_fu_b", m_b, 4'hE);
        wait_result("self2", 2, 4'hC, 2'd0);
        check_dbg("self_reg0", 2'd0, 4'hC);
        check_dbg("regop_reg3", 2'd3, 4'hA);

        // Latency 0 build: load, then wb_en=0
        cur = 1;
        #1;
        issue(mk(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 4'h7));
        wait_result("l0_load", 1, 4'h7, 2'd1);
        issue(mk(4'h0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 4'h2));
        check("l0_fu_a", m_a, 4'h7);
        check("l0_fu_b", m_b, 4'h2);
        wait_result("l0_nowb", 1, 4'h9, 2'd1);
        check_dbg("l0_reg1_kept", 2'd1, 4'h7);

        // Latency 3 build: normal op, then reset mid-WAIT
        cur = 2;
        #1;
        issue(mk(4'h0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 4'h9));
        wait_result("l3_load", 4, 4'h9, 2'd2);
        check_dbg("l3_reg2", 2'd2, 4'h9);
        issue(mk(4'h0, 2'd3, 2'd2, 2'd0, 1'b1, 1'b1, 4'h1));
        repeat (2) @(negedge clk);  // now in WAIT
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_res_valid", m_rv, 0);
        check("midrst_ready", m_rdy, 0);
        check("midrst_fu_a", m_a, 0);
        check("midrst_fu_b", m_b, 0);
        check("midrst_res_data", m_rd, 0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_rel", m_rdy, 1);
        repeat (5) @(negedge clk);
        check_dbg("midrst_reg3", 2'd3, 4'h0);
        check_dbg("midrst_reg2", 2'd2, 4'h0);

        check("pulses_l1", pulses_l1, 7);
        check("pulses_l0", pulses_l0, 2);
        check("pulses_l3", pulses_l3, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fu_sequencer.md
Name: fu_sequencer

Overview:
Instruction-issuing controller that drives the function unit's operand and select inputs and captures its result.
- Accepts one 16-bit instruction per valid/ready handshake.
- Reads operands from an internal 4-entry register file, presents A/B/F_sel to the function unit and waits a fixed latency.
- Samples F_out, optionally writes it back, and reports the result.
- Sits between instruction fetch and the function unit.

Parameters:
WIDTH, 4, datapath/register width (matches function unit operand width)
FU_LATENCY, 1, cycles between operands stable at function unit and F_out valid (0 = combinational)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept (IDLE only)
instr  input  16  [15:12] F_sel, [11:10] rd, [9:8] ra, [7:6] rb, [5] use_imm, [4] wb_en, [3:0] imm
fu_a  output  WIDTH  to function unit A_data
fu_b  output  WIDTH  to function unit B_data
fu_sel  output  4  to function unit F_sel ([3]=logic/arith, [2:1] op, [0] carry-in)
fu_out  input  WIDTH  from function unit F_out
res_valid  output  1  one-cycle pulse, result reported
res_data  output  WIDTH  captured F_out, held until next res_valid
res_rd  output  2  destination index of reported result
dbg_addr  input  2  register-file debug read index
dbg_data  output  WIDTH  combinational read of reg[dbg_addr]

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; regs[0..3]=0; fu_a/fu_b/fu_sel=0; res_valid=0; res_data=0; res_rd=0; wait counter=0. instr_ready=0 while rst_n=0, 1 from the first cycle after release.
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE: instr_ready=1. On instr_valid at edge T: latch fu_sel<=instr[15:12], fu_a<=regs[ra], fu_b<=(use_imm ? zero-extended imm : regs[rb]), latch rd/wb_en; go ISSUE. Otherwise stay.
- ISSUE (cycle T+1): operands valid at the function unit. FU_LATENCY=0 -> go WRITE at the next edge, sampling fu_out. FU_LATENCY>0 -> load counter=FU_LATENCY-1, go WAIT.
- WAIT: decrement counter each cycle. At count 0, the next edge samples fu_out and goes WRITE.
- Sample edge is T+1+FU_LATENCY. fu_a/fu_b/fu_sel stay stable from T+1 through the sample edge, then keep their values until the next accept.
- Sample edge: res_data<=fu_out; res_rd<=rd; if wb_en, regs[rd]<=fu_out.
- WRITE: res_valid=1 for exactly one cycle (T+2+FU_LATENCY); go IDLE.
- Accept-to-accept minimum: FU_LATENCY+3 cycles. instr_ready=0 in ISSUE/WAIT/WRITE; instr_valid ignored there.
- Hazards: none. Operands are read at accept, after any prior write-back has committed.
- rd==ra or rd==rb is legal: the source value is read at accept, and the write lands later.
- wb_en=0: result reported, register file unchanged.
- Reset mid-operation: abort immediately, no write-back, no res_valid, all outputs to reset values.
- Widths: imm zero-extended to WIDTH. The function unit handles arithmetic wrap; the sequencer never modifies fu_out.
- dbg_data is a combinational read; it shows a write-back from the edge after that edge.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/WAIT/WRITE); instruction field bit-position constants; F_sel field constants (SEL_LOGIC bit 3, OP bits 2:1, CIN bit 0).
- Sub-module fu_regfile: 4xWIDTH, one write port, three combinational read ports (ra, rb, dbg), synchronous active-low reset to zero.

Test Plan:
Bench stub function unit: F_out = A+B+F_sel mod 16, delayed by FU_LATENCY cycles.
- Reset then idle: rst_n low 3 cycles -> all outputs 0, instr_ready=0; after release instr_ready=1, regs all 0, res_valid never pulses.
- Immediate load, FU_LATENCY=1: instr F_sel=0, rd=1, use_imm=1, imm=4'h5, wb_en=1 accepted at T -> fu_a=0, fu_b=5 at T+1; res_valid at T+3 with res_data=5, res_rd=1; dbg_addr=1 reads 5.
- Register op and ready timing: with reg1=5, reg2=3, instr F_sel=4'b0010, rd=3, ra=1, rb=2 -> res_data=A; instr_ready low T+1..T+3, high T+4; a second valid held during the busy window is accepted only at T+4.
- Wrap and self-update: reg0=4'hF, instr F_sel=4'h1, rd=0, ra=0, rb=0 -> fu_a=F, fu_b=F, res_data=(F+F+1)&F=4'hF; back-to-back repeat reads the updated reg0.
- wb_en=0 and FU_LATENCY=0 build: result reported with res_valid at T+2, register file unchanged.
- Reset mid-WAIT (FU_LATENCY=3): rst_n low during WAIT -> no res_valid, dest register unchanged (stays 0 after reset), instr_ready=1 the cycle after release.
